// File: rtl/select_pkg.sv
// Shared types and helpers for the select/extract pipeline.
package select_pkg;

   typedef enum logic [1:0] {
      SEL_ZEXT = 2'd0,
      SEL_SEXT = 2'd1,
      SEL_BIT  = 2'd2,
      SEL_RSVD = 2'd3
   } sel_mode_e;

   // Widest field/result the extension helper supports.
   localparam int unsigned MAX_W = 64;

   // Sign-extend the low fw bits of field across MAX_W bits.
   function automatic logic [MAX_W-1:0] sext_field(input logic [MAX_W-1:0] field,
                                                   input int unsigned     fw);
      logic [MAX_W-1:0] upper;
      upper = {MAX_W{1'b1}} << fw;
      sext_field = field[6'(fw - 1)] ? (field | upper) : (field & ~upper);
   endfunction

endpackage

// File: rtl/select_pipe_stage.sv
// Generic valid/ready register slice; accepts whenever empty or draining.
module select_pipe_stage #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: rtl/select_extract_pipe.sv
// Two-stage field extractor: S1 selects the raw field, S2 applies the extension mode.
module select_extract_pipe
   import select_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned FIELD_W = 8,
   parameter int unsigned OUT_W   = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [DATA_W-1:0]    in_word,
   input  logic [$clog2(DATA_W)-1:0]   in_offset,
   input  sel_mode_e                   in_mode,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_W-1:0]            out_data,
   output logic                        out_err,
   output logic [CNT_W-1:0]            err_count
);

   localparam int unsigned EXT_W = DATA_W + FIELD_W;
   localparam int unsigned S1_W  = FIELD_W + 4;
   localparam int unsigned S2_W  = OUT_W + 1;

   logic [EXT_W-1:0]   ext_word;
   logic [FIELD_W-1:0] in_field;
   logic               in_bit;
   logic               range_err;
   logic               in_err;
   logic [31:0]        span;

   logic               s1_valid;
   logic               s1_ready;
   logic [S1_W-1:0]    s1_q;
   logic [FIELD_W-1:0] s1_field;
   logic               s1_bit;
   logic [1:0]         s1_mode;
   logic               s1_err;

   logic [OUT_W-1:0]   s2_data;
   logic [S2_W-1:0]    s2_q;

   // Zero-fill above the word so reads past DATA_W-1 return 0, never sign bits.
   assign ext_word  = EXT_W'($unsigned(in_word));
   assign in_field  = FIELD_W'(ext_word >> in_offset);
   assign in_bit    = 1'(ext_word >> in_offset);
   assign span      = 32'(in_offset) + 32'(FIELD_W);
   assign range_err = span > 32'(DATA_W);

   always_comb begin
      in_err = range_err;
      case (in_mode)
         SEL_BIT:  in_err = 1'b0;
         SEL_RSVD: in_err = 1'b1;
         default:  ;
      endcase
   end

   select_pipe_stage #(.W(S1_W)) u_s1 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({in_field, in_bit, in_mode, in_err}),
      .out_valid (s1_valid),
      .out_ready (s1_ready),
      .out_data  (s1_q)
   );

   assign {s1_field, s1_bit, s1_mode, s1_err} = s1_q;

   // Reserved mode falls through to zero extension.
   always_comb begin
      s2_data = OUT_W'(s1_field);
      case (sel_mode_e'(s1_mode))
         SEL_SEXT: s2_data = OUT_W'(sext_field(MAX_W'(s1_field), FIELD_W));
         SEL_BIT:  s2_data = OUT_W'(s1_bit);
         default:  ;
      endcase
   end

   select_pipe_stage #(.W(S2_W)) u_s2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (s1_valid),
      .in_ready  (s1_ready),
      .in_data   ({s2_data, s1_err}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (s2_q)
   );

   assign {out_data, out_err} = s2_q;

   // Errors are counted at input acceptance, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (in_valid && in_ready && in_err && (err_count != {CNT_W{1'b1}})) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule
